// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the RAM command bus and the arbiter state machine.
package mem_arbiter_pkg;

    // RAM command encodings, shared with the CPU controller and RAM wrapper.
    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10,
        MBAD   = 2'b11
    } mem_cmd_e;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ISSUE  = 2'b01,
        RDWAIT = 2'b10
    } arb_state_e;

    // True for the two commands that actually touch the RAM.
    function automatic logic cmd_is_access(input logic [1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way request picker: round-robin on ties or fixed priority to port 0.
module arb_rr2 #(
    parameter int ARB_MODE = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_sel,
    output logic valid
);

    // Choose the winning port; a tie goes to the port not granted last time
    // unless fixed priority is selected.
    always_comb begin
        grant_sel = 1'b0;
        valid     = req0 | req1;
        if (req0 && req1) begin
            if (ARB_MODE != 0) begin
                grant_sel = 1'b0;
            end else begin
                grant_sel = ~last_grant;
            end
        end else if (req1) begin
            grant_sel = 1'b1;
        end else begin
            grant_sel = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-ported data/instruction RAM.
// Serialises CPU and debug/DMA accesses, one transaction in flight.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW       = 9,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic [1:0]    cmd0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          ack0,
    input  logic          req1,
    input  logic [1:0]    cmd1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner,
    output logic          bad_cmd
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

    arb_state_e    state_r;
    logic [1:0]    cap_cmd_r;
    logic [1:0]    cnt_r;
    logic          last_grant_r;
    logic          rd_ack_r;
    logic [DW-1:0] rdata_hold_r;

    logic          grant_sel_s;
    logic          grant_valid_s;
    logic [1:0]    sel_cmd_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;

    arb_rr2 #(
        .ARB_MODE(ARB_MODE)
    ) u_pick (
        .req0      (req0),
        .req1      (req1),
        .last_grant(last_grant_r),
        .grant_sel (grant_sel_s),
        .valid     (grant_valid_s)
    );

    // Route the winning port's command, address and data to the capture path.
    always_comb begin
        sel_cmd_s   = cmd0;
        sel_addr_s  = addr0;
        sel_wdata_s = wdata0;
        if (grant_sel_s) begin
            sel_cmd_s   = cmd1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_cmd_s   = cmd0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    // Read data is live from the RAM during the read ack cycle, then held.
    always_comb begin
        if (rd_ack_r) begin
            rdata = mem_rdata;
        end else begin
            rdata = rdata_hold_r;
        end
    end

    // Arbiter FSM: capture in IDLE, drive the bus in ISSUE/RDWAIT, all
    // handshake and bus outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            cap_cmd_r    <= MNONE;
            cnt_r        <= 2'd0;
            last_grant_r <= 1'b1;
            rd_ack_r     <= 1'b0;
            rdata_hold_r <= {DW{1'b0}};
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            mem_cmd      <= MNONE;
            mem_addr     <= {AW{1'b0}};
            mem_wdata    <= {DW{1'b0}};
            busy         <= 1'b0;
            owner        <= 1'b0;
            bad_cmd      <= 1'b0;
        end else begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rd_ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        state_r      <= ISSUE;
                        busy         <= 1'b1;
                        owner        <= grant_sel_s;
                        last_grant_r <= grant_sel_s;
                        cap_cmd_r    <= sel_cmd_s;
                        mem_addr     <= sel_addr_s;
                        mem_wdata    <= sel_wdata_s;
                        mem_cmd      <= cmd_is_access(sel_cmd_s) ? sel_cmd_s : MNONE;
                        gnt0         <= ~grant_sel_s;
                        gnt1         <= grant_sel_s;
                        // Writes and non-accesses complete in the ISSUE cycle.
                        if (sel_cmd_s != MREAD) begin
                            ack0 <= ~grant_sel_s;
                            ack1 <= grant_sel_s;
                        end
                        if (sel_cmd_s == MBAD) begin
                            bad_cmd <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (cap_cmd_r == MREAD) begin
                        state_r <= RDWAIT;
                        cnt_r   <= 2'd1;
                        if (LAT_LAST == 2'd1) begin
                            ack0     <= ~owner;
                            ack1     <= owner;
                            rd_ack_r <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        mem_cmd <= MNONE;
                    end
                end
                RDWAIT: begin
                    if (cnt_r == LAT_LAST) begin
                        state_r      <= IDLE;
                        busy         <= 1'b0;
                        mem_cmd      <= MNONE;
                        rdata_hold_r <= mem_rdata;
                    end else begin
                        cnt_r <= cnt_r + 2'd1;
                        // Ack is registered, so raise it one edge ahead of the
                        // cycle where the counter reaches the latency.
                        if ((cnt_r + 2'd1) == LAT_LAST) begin
                            ack0     <= ~owner;
                            ack1     <= owner;
                            rd_ack_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    mem_cmd <= MNONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LAT=1 round-robin, RD_LAT=3 fixed
// priority) sharing the same requester inputs, each with its own RAM.
module tb_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_ram;
    logic          req0, req1;
    logic [1:0]    cmd0, cmd1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    wire [1:0]          g0, g1, k0, k1, bz, ow, bd;
    wire [1:0][1:0]     mc;
    wire [1:0][AW-1:0]  ma;
    wire [1:0][DW-1:0]  mw, rd;
    wire [DW-1:0]       mr_a, mr_b;

    logic [DW-1:0] ram_a [512];
    logic [DW-1:0] ram_b [512];
    logic [AW-1:0] pa_a;
    logic [AW-1:0] pa_b [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .ARB_MODE(0)) u_dut_a (
        .clk(clk), .reset(reset),
        .req0(req0), .cmd0(cmd0), .addr0(addr0), .wdata0(wdata0), .gnt0(g0[0]), .ack0(k0[0]),
        .req1(req1), .cmd1(cmd1), .addr1(addr1), .wdata1(wdata1), .gnt1(g1[0]), .ack1(k1[0]),
        .rdata(rd[0]), .mem_cmd(mc[0]), .mem_addr(ma[0]), .mem_wdata(mw[0]), .mem_rdata(mr_a),
        .busy(bz[0]), .owner(ow[0]), .bad_cmd(bd[0])
    );

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .ARB_MODE(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .req0(req0), .cmd0(cmd0), .addr0(addr0), .wdata0(wdata0), .gnt0(g0[1]), .ack0(k0[1]),
        .req1(req1), .cmd1(cmd1), .addr1(addr1), .wdata1(wdata1), .gnt1(g1[1]), .ack1(k1[1]),
        .rdata(rd[1]), .mem_cmd(mc[1]), .mem_addr(ma[1]), .mem_wdata(mw[1]), .mem_rdata(mr_b),
        .busy(bz[1]), .owner(ow[1]), .bad_cmd(bd[1])
    );

    // RAMs: write on MWRITE, read data appears RD_LAT cycles after the address.
    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 512; i++) begin
                ram_a[i] <= 16'h5A00 ^ 16'(i);
                ram_b[i] <= 16'h5A00 ^ 16'(i);
            end
        end else begin
            if (mc[0] == 2'b10) ram_a[ma[0]] <= mw[0];
            if (mc[1] == 2'b10) ram_b[ma[1]] <= mw[1];
        end
        pa_a    <= ma[0];
        pa_b[0] <= ma[1];
        pa_b[1] <= pa_b[0];
        pa_b[2] <= pa_b[1];
    end
    assign mr_a = ram_a[pa_a];
    assign mr_b = ram_b[pa_b[2]];

    task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic drive_req(input logic p, input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] w);
        req0 = ~p; req1 = p;
        cmd0 = c; cmd1 = c; addr0 = a; addr1 = a; wdata0 = w; wdata1 = w;
    endtask

    typedef struct {
        logic          port;
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    exp_mcmd;
        logic [DW-1:0] exp_rdata;
        int            lat_a;
        int            lat_b;
        logic          exp_bad;
    } vec_t;
    vec_t vecs[9];

    // Transaction-level reference model state, one slot per instance.
    int            m_start[2], m_done[2], m_free[2], m_bad_at[2], m_lat[2], m_mode[2];
    logic          m_own[2], m_last[2];
    logic [1:0]    m_cmd[2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_wd[2], m_exp_rd[2];
    logic [DW-1:0] m_ram[2][512];

    initial begin
        int lat_seen[2], acks[2], wrong[2], cmd_cyc[2], first_ack[2], first_gnt[2];
        logic [DW-1:0] rd_val[2];
        int gq_a[$], gq_b[$];
        int exp_cyc;
        logic in_t, w;
        logic [1:0] exp_mc;
        int e, r;

        vecs[0] = '{1'b0, 2'b10, 9'h005, 16'hABCD, 2'b10, 16'h0000, 0, 0, 1'b0};
        vecs[1] = '{1'b1, 2'b01, 9'h005, 16'h0000, 2'b01, 16'hABCD, 1, 3, 1'b0};
        vecs[2] = '{1'b0, 2'b01, 9'h005, 16'h0000, 2'b01, 16'hABCD, 1, 3, 1'b0};
        vecs[3] = '{1'b1, 2'b10, 9'h1FF, 16'h1234, 2'b10, 16'h0000, 0, 0, 1'b0};
        vecs[4] = '{1'b0, 2'b01, 9'h1FF, 16'h0000, 2'b01, 16'h1234, 1, 3, 1'b0};
        vecs[5] = '{1'b1, 2'b00, 9'h000, 16'h0000, 2'b00, 16'h0000, 0, 0, 1'b0};
        vecs[6] = '{1'b0, 2'b11, 9'h003, 16'h7777, 2'b00, 16'h0000, 0, 0, 1'b1};
        vecs[7] = '{1'b1, 2'b10, 9'h000, 16'hFFFF, 2'b10, 16'h0000, 0, 0, 1'b1};
        vecs[8] = '{1'b0, 2'b01, 9'h000, 16'h0000, 2'b01, 16'hFFFF, 1, 3, 1'b1};

        m_lat[0] = 1; m_lat[1] = 3; m_mode[0] = 0; m_mode[1] = 1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 512; i++) m_ram[d][i] = 16'h5A00 ^ 16'(i);

        // Reset state.
        reset = 1'b0; init_ram = 1'b1;
        req0 = 1'b0; req1 = 1'b0; cmd0 = 2'b00; cmd1 = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk(d, "rst_busy", 32'(bz[d]), 32'd0);
            chk(d, "rst_gnt", 32'({g0[d], g1[d]}), 32'd0);
            chk(d, "rst_ack", 32'({k0[d], k1[d]}), 32'd0);
            chk(d, "rst_mem_cmd", 32'(mc[d]), 32'd0);
            chk(d, "rst_rdata", 32'(rd[d]), 32'd0);
            chk(d, "rst_owner", 32'(ow[d]), 32'd0);
            chk(d, "rst_bad", 32'(bd[d]), 32'd0);
        end
        reset = 1'b1; init_ram = 1'b0;

        // Both ports requesting continuously.
        req0 = 1'b1; req1 = 1'b1; cmd0 = 2'b10; cmd1 = 2'b10;
        addr0 = 9'h00A; addr1 = 9'h00B; wdata0 = 16'h1111; wdata1 = 16'h2222;
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            if (g0[0]) gq_a.push_back(0);
            if (g1[0]) gq_a.push_back(1);
            if (g0[1]) gq_b.push_back(0);
            if (g1[1]) gq_b.push_back(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (6) @(negedge clk);
        chk(0, "tie_grant_count", 32'(gq_a.size() >= 4), 32'd1);
        chk(1, "tie_grant_count", 32'(gq_b.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < gq_a.size()) chk(0, "tie_rr_order", 32'(gq_a[i]), 32'(i % 2));
            if (i < gq_b.size()) chk(1, "tie_fixed_order", 32'(gq_b[i]), 32'd0);
        end

        // Directed single transactions.
        for (int v = 0; v < 9; v++) begin
            drive_req(vecs[v].port, vecs[v].cmd, vecs[v].addr, vecs[v].wdata);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk(d, "vec_gnt", 32'({g1[d], g0[d]}), vecs[v].port ? 32'd2 : 32'd1);
                chk(d, "vec_mem_cmd", 32'(mc[d]), 32'(vecs[v].exp_mcmd));
                chk(d, "vec_owner", 32'(ow[d]), 32'(vecs[v].port));
                if (vecs[v].exp_mcmd != 2'b00) chk(d, "vec_mem_addr", 32'(ma[d]), 32'(vecs[v].addr));
                if (vecs[v].cmd == 2'b10) chk(d, "vec_mem_wdata", 32'(mw[d]), 32'(vecs[v].wdata));
                lat_seen[d] = -1; acks[d] = 0; wrong[d] = 0; cmd_cyc[d] = 0; rd_val[d] = '0;
            end
            req0 = 1'b0; req1 = 1'b0;
            for (int j = 0; j < 8; j++) begin
                if (j > 0) @(negedge clk);
                for (int d = 0; d < 2; d++) begin
                    if (mc[d] != 2'b00) cmd_cyc[d]++;
                    if (vecs[v].port ? k0[d] : k1[d]) wrong[d]++;
                    if (vecs[v].port ? k1[d] : k0[d]) begin
                        acks[d]++; lat_seen[d] = j; rd_val[d] = rd[d];
                    end
                end
            end
            for (int d = 0; d < 2; d++) begin
                exp_cyc = (vecs[v].cmd == 2'b01) ? ((d == 0 ? vecs[v].lat_a : vecs[v].lat_b) + 1)
                        : ((vecs[v].cmd == 2'b10) ? 1 : 0);
                chk(d, "vec_ack_count", 32'(acks[d]), 32'd1);
                chk(d, "vec_wrong_ack", 32'(wrong[d]), 32'd0);
                chk(d, "vec_ack_latency", 32'(lat_seen[d]), 32'(d == 0 ? vecs[v].lat_a : vecs[v].lat_b));
                chk(d, "vec_cmd_cycles", 32'(cmd_cyc[d]), 32'(exp_cyc));
                if (vecs[v].cmd == 2'b01) chk(d, "vec_rdata", 32'(rd_val[d]), 32'(vecs[v].exp_rdata));
                chk(d, "vec_bad_cmd", 32'(bd[d]), 32'(vecs[v].exp_bad));
            end
        end

        // Port 1 request arriving while port 0's read is in progress.
        drive_req(1'b0, 2'b01, 9'h005, 16'h0000);
        for (int d = 0; d < 2; d++) begin first_ack[d] = -1; first_gnt[d] = -1; end
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (j == 0) req0 = 1'b0;
            if (j == 1) begin
                req1 = 1'b1; cmd1 = 2'b10; addr1 = 9'h020; wdata1 = 16'h5555;
            end
            for (int d = 0; d < 2; d++) begin
                if (k0[d] && first_ack[d] < 0) first_ack[d] = j;
                if (g1[d] && first_gnt[d] < 0) first_gnt[d] = j;
            end
            if (first_gnt[0] >= 0 && first_gnt[1] >= 0) req1 = 1'b0;
        end
        chk(0, "late_ack0", 32'(first_ack[0]), 32'd1);
        chk(1, "late_ack0", 32'(first_ack[1]), 32'd3);
        chk(0, "late_gnt1", 32'(first_gnt[0]), 32'd3);
        chk(1, "late_gnt1", 32'(first_gnt[1]), 32'd5);

        // Reset asserted while reads are outstanding.
        drive_req(1'b0, 2'b01, 9'h1FF, 16'h0000);
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk(1, "midrst_busy_before_edge", 32'(bz[1]), 32'd0);
        for (int d = 0; d < 2; d++) begin
            chk(d, "midrst_mem_cmd", 32'(mc[d]), 32'd0);
            chk(d, "midrst_ack", 32'({k0[d], k1[d]}), 32'd0);
            chk(d, "midrst_bad", 32'(bd[d]), 32'd0);
            chk(d, "midrst_rdata", 32'(rd[d]), 32'd0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int d = 0; d < 2; d++) acks[d] = 0;
        repeat (4) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) if (k0[d] || k1[d] || bz[d]) acks[d]++;
        end
        for (int d = 0; d < 2; d++) chk(d, "midrst_no_ack", 32'(acks[d]), 32'd0);
        req0 = 1'b1; req1 = 1'b1; cmd0 = 2'b10; cmd1 = 2'b10;
        addr0 = 9'h00A; addr1 = 9'h00B;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk(d, "midrst_first_grant", 32'({g1[d], g0[d]}), 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(negedge clk);

        // Random traffic against the transaction-level model.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_start[d] = -10; m_done[d] = -10; m_free[d] = 1; m_last[d] = 1'b1;
            m_own[d] = 1'b0; m_cmd[d] = 2'b00; m_bad_at[d] = 1 << 30;
        end
        for (int c = 0; c < 2500; c++) begin
            if (c > 0) @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                in_t = (c >= m_start[d]) && (c <= m_done[d]);
                exp_mc = (in_t && (m_cmd[d] == 2'b01 || m_cmd[d] == 2'b10)) ? m_cmd[d] : 2'b00;
                chk(d, "rnd_busy", 32'(bz[d]), 32'(in_t));
                if (in_t) chk(d, "rnd_owner", 32'(ow[d]), 32'(m_own[d]));
                chk(d, "rnd_gnt0", 32'(g0[d]), 32'(in_t && c == m_start[d] && !m_own[d]));
                chk(d, "rnd_gnt1", 32'(g1[d]), 32'(in_t && c == m_start[d] && m_own[d]));
                chk(d, "rnd_ack0", 32'(k0[d]), 32'(in_t && c == m_done[d] && !m_own[d]));
                chk(d, "rnd_ack1", 32'(k1[d]), 32'(in_t && c == m_done[d] && m_own[d]));
                chk(d, "rnd_mem_cmd", 32'(mc[d]), 32'(exp_mc));
                if (exp_mc != 2'b00) chk(d, "rnd_mem_addr", 32'(ma[d]), 32'(m_addr[d]));
                if (exp_mc == 2'b10) chk(d, "rnd_mem_wdata", 32'(mw[d]), 32'(m_wd[d]));
                if (in_t && c == m_done[d] && m_cmd[d] == 2'b01)
                    chk(d, "rnd_rdata", 32'(rd[d]), 32'(m_exp_rd[d]));
                chk(d, "rnd_bad", 32'(bd[d]), 32'(c >= m_bad_at[d]));
            end
            req0 = ($urandom_range(0, 99) < 45);
            req1 = ($urandom_range(0, 99) < 45);
            r = $urandom_range(0, 29);
            cmd0 = (r == 0) ? 2'b11 : (r < 3) ? 2'b00 : (r < 16) ? 2'b01 : 2'b10;
            r = $urandom_range(0, 29);
            cmd1 = (r == 0) ? 2'b11 : (r < 3) ? 2'b00 : (r < 16) ? 2'b01 : 2'b10;
            addr0 = 9'h100 | 9'($urandom_range(0, 15));
            addr1 = 9'h100 | 9'($urandom_range(0, 15));
            wdata0 = 16'($urandom);
            wdata1 = 16'($urandom);
            e = c + 1;
            for (int d = 0; d < 2; d++) begin
                if (e >= m_free[d] && (req0 || req1)) begin
                    if (req0 && req1) w = (m_mode[d] != 0) ? 1'b0 : ~m_last[d];
                    else w = req1;
                    m_last[d] = w; m_own[d] = w;
                    m_cmd[d] = w ? cmd1 : cmd0;
                    m_addr[d] = w ? addr1 : addr0;
                    m_wd[d] = w ? wdata1 : wdata0;
                    m_start[d] = e;
                    m_done[d] = e + ((m_cmd[d] == 2'b01) ? m_lat[d] : 0);
                    m_free[d] = m_done[d] + 2;
                    if (m_cmd[d] == 2'b10) m_ram[d][m_addr[d]] = m_wd[d];
                    if (m_cmd[d] == 2'b01) m_exp_rd[d] = m_ram[d][m_addr[d]];
                    if (m_cmd[d] == 2'b11 && m_bad_at[d] > e) m_bad_at[d] = e;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
